friscv_apb_demux: RTL and testbench
===================================

// Module: friscv_apb_demux
// PURPOSE
//  Parametrised 1-master / NB_SLV-slave APB-style bus router for the IO subsystem; next generation of the 2-slave interconnect.
//  Decodes the master address against a per-slave base/size map and forwards the request to one slave, with a relative address.
//  Registers the response, flags decode misses and slave timeouts on mst_err, and never hangs the master.
// PARAMETERS
//  ADDRW    16      address width
//  XLEN     32      data width; strobe width is XLEN/8
//  NB_SLV   4       number of slaves, 1..16
//  SLV_ADDR {0,8,24,40} packed NB_SLV*ADDRW; base of slave i at bits [i*ADDRW +: ADDRW]
//  SLV_SIZE {8,16,16,16} packed NB_SLV*ADDRW; byte size of slave i; 0 disables slave i
//  TIMEOUT  64      max cycles waiting for slv_ready; 0 = no timeout
// PORTS
//  aclk       in  1              clock, all logic on rising edge
//  aresetn    in  1              asynchronous active-low reset
//  mst_en     in  1              master request, held stable until mst_ready
//  mst_wr     in  1              1=write, 0=read
//  mst_addr   in  ADDRW          byte address
//  mst_wdata  in  XLEN           write data
//  mst_strb   in  XLEN/8         byte write strobes
//  mst_rdata  out XLEN           read data, valid with mst_ready
//  mst_ready  out 1              one-cycle completion pulse
//  mst_err    out 1              valid with mst_ready: decode miss or timeout
//  slv_en     out NB_SLV         per-slave request, one-hot or zero
//  slv_wr     out 1              shared, copy of mst_wr
//  slv_addr   out ADDRW          shared, mst_addr - SLV_ADDR[sel]
//  slv_wdata  out XLEN           shared, copy of mst_wdata
//  slv_strb   out XLEN/8         shared, copy of mst_strb
//  slv_rdata  in  NB_SLV*XLEN    per-slave read data, slave i at [i*XLEN +: XLEN]
//  slv_ready  in  NB_SLV         per-slave completion
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0, including slv_en, mst_ready, mst_err, mst_rdata and the slv_* copies; timeout counter 0.
//  Decode: hit_i = SLV_SIZE[i]!=0 && addr>=SLV_ADDR[i] && addr<SLV_ADDR[i]+SLV_SIZE[i].
//  Decode, cont.: compute the sum at ADDRW+1 bits, so no wrap at the top of the map. Overlaps resolve to the lowest index.
//  FSM IDLE:
//   mst_en=1 with a hit: register slv_en[sel]=1, wr/addr/wdata/strb and sel; go to ACCESS.
//   mst_en=1 with no hit: mst_ready<=1, mst_err<=1, mst_rdata<=0; go to RESP, no slave touched.
//  FSM ACCESS: slv_en[sel] held. Each cycle, slv_ready[sel]=1 does:
//   slv_en<=0, mst_ready<=1, mst_err<=0; mst_rdata<=slv_rdata[sel] on a read, 0 on a write; go to RESP.
//   slv_ready of non-selected slaves is ignored.
//   Counter increments each ACCESS cycle without ready. When it reaches TIMEOUT-1 with no ready:
//   slv_en<=0, mst_ready<=1, mst_err<=1, mst_rdata<=0; go to RESP.
//   The counter clears on leaving ACCESS.
//  FSM RESP: mst_ready high for exactly this cycle; mst_en is ignored; next state IDLE.
//   A back-to-back request held on mst_en is sampled in IDLE on the following cycle.
//  Latency: hit with a zero-wait slave is mst_en@t, slv_en@t+1, slv_ready@t+1, mst_ready@t+2. A miss gives mst_ready@t+1.
//  Throughput: one transaction per 3 cycles at best.
//  At most one slv_en bit is set at any time. slv_* copies stay stable while slv_en is high.
//  Reset mid-transaction: all state and outputs clear immediately, the transaction is dropped, no mst_ready is issued.
// TESTING
//  Read slave 1 (base 8) at addr 0x0C, slave gives ready next cycle with 0xCAFE0001:
//   -> slv_en=4'b0010, slv_addr=0x4; mst_ready@t+2, rdata=0xCAFE0001, err=0.
//  Write addr 0x28, strb 4'b0011, data 0x1234: slv_en=4'b1000, slv_addr=0, slv_strb=3; slave delays ready 5 cycles:
//   -> slv_en held 6 cycles, then mst_ready with err=0.
//  Read addr 0x100 (unmapped) -> no slv_en, mst_ready@t+1 with err=1, rdata=0.
//  TIMEOUT=4, slave 2 never ready -> slv_en[2] high 4 cycles, then drops; mst_ready with err=1.
//   Next request to slave 0 completes normally.
//  Back-to-back: mst_en held high over 3 requests to slaves 0,1,0 -> three one-cycle mst_ready pulses, 3 cycles apart.
//   No duplicate slave access.
//  aresetn low while in ACCESS -> slv_en=0 and mst_ready=0 asynchronously; after release, the FSM is in IDLE.

Source files
------------

// File: rtl/friscv_apb_demux.sv
// friscv_apb_demux: one APB-style master routed to NB_SLV slaves.
// The master address is decoded against a base/size map. The request goes to one slave with a relative address.
// The response is registered. Decode misses and slave timeouts complete with mst_err set, so the master never hangs.
module friscv_apb_demux #(
    parameter int ADDRW  = 16,
    parameter int XLEN   = 32,
    parameter int NB_SLV = 4,
    parameter logic [NB_SLV*ADDRW-1:0] SLV_ADDR = {16'd40, 16'd24, 16'd8, 16'd0},
    parameter logic [NB_SLV*ADDRW-1:0] SLV_SIZE = {16'd16, 16'd16, 16'd16, 16'd8},
    parameter int TIMEOUT = 64
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   mst_en,
    input  logic                   mst_wr,
    input  logic [ADDRW-1:0]       mst_addr,
    input  logic [XLEN-1:0]        mst_wdata,
    input  logic [XLEN/8-1:0]      mst_strb,
    output logic [XLEN-1:0]        mst_rdata,
    output logic                   mst_ready,
    output logic                   mst_err,
    output logic [NB_SLV-1:0]      slv_en,
    output logic                   slv_wr,
    output logic [ADDRW-1:0]       slv_addr,
    output logic [XLEN-1:0]        slv_wdata,
    output logic [XLEN/8-1:0]      slv_strb,
    input  logic [NB_SLV*XLEN-1:0] slv_rdata,
    input  logic [NB_SLV-1:0]      slv_ready
);

    localparam int SELW = (NB_SLV > 1) ? $clog2(NB_SLV) : 1;
    localparam int CNTW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [SELW-1:0]     sel, sel_d;
    logic [CNTW-1:0]     cnt, cnt_d;
    logic [NB_SLV-1:0]   slv_en_d;
    logic                slv_wr_d;
    logic [ADDRW-1:0]    slv_addr_d;
    logic [XLEN-1:0]     slv_wdata_d;
    logic [XLEN/8-1:0]   slv_strb_d;
    logic                mst_ready_d;
    logic                mst_err_d;
    logic [XLEN-1:0]     mst_rdata_d;

    logic                hit;
    logic [SELW-1:0]     hit_sel;
    logic [ADDRW-1:0]    hit_base;
    logic [ADDRW-1:0]    base;
    logic [ADDRW-1:0]    size;
    logic [XLEN-1:0]     sel_rdata;
    logic                sel_ready;

    // Address decode; limits are summed at ADDRW+1 bits so a region ending at the top of the map does not wrap.
    // The first hit found is kept, so the lowest index wins on overlap.
    always_comb begin
        hit      = 1'b0;
        hit_sel  = '0;
        hit_base = '0;
        base     = '0;
        size     = '0;
        for (int unsigned i = 0; i < NB_SLV; i++) begin
            base = SLV_ADDR[i*ADDRW +: ADDRW];
            size = SLV_SIZE[i*ADDRW +: ADDRW];
            if (!hit && size != '0 && mst_addr >= base &&
                {1'b0, mst_addr} < ({1'b0, base} + {1'b0, size})) begin
                hit      = 1'b1;
                hit_sel  = SELW'(i);
                hit_base = base;
            end
        end
    end

    // Response mux for the slave being accessed; other slaves' ready lines are ignored.
    always_comb begin
        sel_rdata = slv_rdata[32'(sel)*XLEN +: XLEN];
        sel_ready = slv_ready[sel];
    end

    // Next-state and next-output logic for the IDLE / ACCESS / RESP sequence.
    always_comb begin
        state_d     = state;
        sel_d       = sel;
        cnt_d       = cnt;
        slv_en_d    = slv_en;
        slv_wr_d    = slv_wr;
        slv_addr_d  = slv_addr;
        slv_wdata_d = slv_wdata;
        slv_strb_d  = slv_strb;
        mst_ready_d = 1'b0;
        mst_err_d   = mst_err;
        mst_rdata_d = mst_rdata;
        case (state)
            IDLE: begin
                if (mst_en) begin
                    if (hit) begin
                        slv_en_d    = NB_SLV'(1) << hit_sel;
                        slv_wr_d    = mst_wr;
                        slv_addr_d  = mst_addr - hit_base;
                        slv_wdata_d = mst_wdata;
                        slv_strb_d  = mst_strb;
                        sel_d       = hit_sel;
                        state_d     = ACCESS;
                    end else begin
                        mst_ready_d = 1'b1;
                        mst_err_d   = 1'b1;
                        mst_rdata_d = '0;
                        state_d     = RESP;
                    end
                end
            end
            ACCESS: begin
                if (sel_ready) begin
                    slv_en_d    = '0;
                    mst_ready_d = 1'b1;
                    mst_err_d   = 1'b0;
                    mst_rdata_d = slv_wr ? '0 : sel_rdata;
                    cnt_d       = '0;
                    state_d     = RESP;
                end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                    slv_en_d    = '0;
                    mst_ready_d = 1'b1;
                    mst_err_d   = 1'b1;
                    mst_rdata_d = '0;
                    cnt_d       = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                slv_en_d = '0;
                cnt_d    = '0;
            end
        endcase
    end

    // State and registered outputs; reset drops any transaction in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            sel       <= '0;
            cnt       <= '0;
            slv_en    <= '0;
            slv_wr    <= 1'b0;
            slv_addr  <= '0;
            slv_wdata <= '0;
            slv_strb  <= '0;
            mst_ready <= 1'b0;
            mst_err   <= 1'b0;
            mst_rdata <= '0;
        end else begin
            state     <= state_d;
            sel       <= sel_d;
            cnt       <= cnt_d;
            slv_en    <= slv_en_d;
            slv_wr    <= slv_wr_d;
            slv_addr  <= slv_addr_d;
            slv_wdata <= slv_wdata_d;
            slv_strb  <= slv_strb_d;
            mst_ready <= mst_ready_d;
            mst_err   <= mst_err_d;
            mst_rdata <= mst_rdata_d;
        end
    end

endmodule

// File: tb/tb_friscv_apb_demux.sv
// Directed bench for friscv_apb_demux: default map instance plus a TIMEOUT=4 instance.
module tb_friscv_apb_demux;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b0;
    logic [127:0] slv_rdata = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

    // main instance signals
    logic        mst_en = 1'b0, mst_wr = 1'b0;
    logic [15:0] mst_addr = '0;
    logic [31:0] mst_wdata = '0;
    logic [3:0]  mst_strb = '0;
    logic [31:0] mst_rdata;
    logic        mst_ready, mst_err;
    logic [3:0]  slv_en, slv_ready, slv_strb;
    logic        slv_wr;
    logic [15:0] slv_addr;
    logic [31:0] slv_wdata;
    logic        auto_rdy = 1'b0;
    logic [3:0]  man_rdy = '0;

    // timeout instance signals
    logic        t_en = 1'b0, t_wr = 1'b0;
    logic [15:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    logic [3:0]  t_strb = '0;
    logic [31:0] t_mst_rdata;
    logic        t_mst_ready, t_mst_err;
    logic [3:0]  t_slv_en, t_slv_ready, t_slv_strb;
    logic        t_slv_wr;
    logic [15:0] t_slv_addr;
    logic [31:0] t_slv_wdata;
    logic        t_auto = 1'b0;

    int n_pass = 0;
    int n_total = 0;

    always #5 aclk = ~aclk;

    // zero-wait responder (ready together with slv_en) or manual ready pattern
    assign slv_ready   = auto_rdy ? slv_en : man_rdy;
    assign t_slv_ready = t_slv_en & {4{t_auto}};

    friscv_apb_demux dut (
        .aclk(aclk), .aresetn(aresetn),
        .mst_en(mst_en), .mst_wr(mst_wr), .mst_addr(mst_addr),
        .mst_wdata(mst_wdata), .mst_strb(mst_strb),
        .mst_rdata(mst_rdata), .mst_ready(mst_ready), .mst_err(mst_err),
        .slv_en(slv_en), .slv_wr(slv_wr), .slv_addr(slv_addr),
        .slv_wdata(slv_wdata), .slv_strb(slv_strb),
        .slv_rdata(slv_rdata), .slv_ready(slv_ready)
    );

    friscv_apb_demux #(.TIMEOUT(4)) dut_to (
        .aclk(aclk), .aresetn(aresetn),
        .mst_en(t_en), .mst_wr(t_wr), .mst_addr(t_addr),
        .mst_wdata(t_wdata), .mst_strb(t_strb),
        .mst_rdata(t_mst_rdata), .mst_ready(t_mst_ready), .mst_err(t_mst_err),
        .slv_en(t_slv_en), .slv_wr(t_slv_wr), .slv_addr(t_slv_addr),
        .slv_wdata(t_slv_wdata), .slv_strb(t_slv_strb),
        .slv_rdata(slv_rdata), .slv_ready(t_slv_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // one read/write on the main instance with a zero-wait slave; exp_en==0 means decode miss
    task automatic xfer(input string tag, input logic [15:0] addr, input logic wr,
                        input logic [3:0] exp_en, input logic [15:0] exp_saddr,
                        input logic exp_err, input logic [31:0] exp_rdata);
        auto_rdy  = 1'b1;
        mst_en    = 1'b1;
        mst_wr    = wr;
        mst_addr  = addr;
        mst_wdata = 32'h5A5A0000 | 32'(addr);
        mst_strb  = 4'hF;
        step();
        if (exp_en != 4'b0000) begin
            check({tag, " slv_en"}, 32'(slv_en), 32'(exp_en));
            check({tag, " slv_addr"}, 32'(slv_addr), 32'(exp_saddr));
            check({tag, " early ready"}, 32'(mst_ready), 32'd0);
            step();
        end
        check({tag, " ready"}, 32'(mst_ready), 32'd1);
        check({tag, " slv_en idle"}, 32'(slv_en), 32'd0);
        check({tag, " err"}, 32'(mst_err), 32'(exp_err));
        check({tag, " rdata"}, mst_rdata, exp_rdata);
        mst_en = 1'b0;
        step();
        check({tag, " ready pulse"}, 32'(mst_ready), 32'd0);
    endtask

    logic [15:0] b2b_addr [3] = '{16'h0004, 16'h000C, 16'h0004};
    logic [3:0]  b2b_en   [3] = '{4'b0001, 4'b0010, 4'b0001};
    logic [31:0] b2b_data [3] = '{32'hCAFE0000, 32'hCAFE0001, 32'hCAFE0000};

    initial begin
        // reset state
        step();
        step();
        check("rst slv_en", 32'(slv_en), 32'd0);
        check("rst ready", 32'(mst_ready), 32'd0);
        check("rst err", 32'(mst_err), 32'd0);
        check("rst rdata", mst_rdata, 32'd0);
        check("rst slv_addr", 32'(slv_addr), 32'd0);
        check("rst slv_wdata", slv_wdata, 32'd0);
        check("rst slv_strb", 32'(slv_strb), 32'd0);
        check("rst slv_wr", 32'(slv_wr), 32'd0);
        aresetn = 1'b1;
        step();

        xfer("rd_s1", 16'h000C, 1'b0, 4'b0010, 16'h0004, 1'b0, 32'hCAFE0001);

        // write to slave 3, slave waits; foreign ready lines must be ignored
        auto_rdy  = 1'b0;
        man_rdy   = 4'b0000;
        mst_en    = 1'b1;
        mst_wr    = 1'b1;
        mst_addr  = 16'h0028;
        mst_wdata = 32'h0000_1234;
        mst_strb  = 4'b0011;
        step();
        check("wr slv_en", 32'(slv_en), 32'h8);
        check("wr slv_addr", 32'(slv_addr), 32'd0);
        check("wr slv_strb", 32'(slv_strb), 32'h3);
        check("wr slv_wdata", slv_wdata, 32'h1234);
        check("wr slv_wr", 32'(slv_wr), 32'd1);
        man_rdy = 4'b0111;
        for (int k = 2; k <= 6; k++) begin
            step();
            check("wr slv_en held", 32'(slv_en), 32'h8);
            check("wr no ready", 32'(mst_ready), 32'd0);
            if (k == 6) man_rdy = 4'b1000;
        end
        step();
        check("wr ready", 32'(mst_ready), 32'd1);
        check("wr err", 32'(mst_err), 32'd0);
        check("wr rdata", mst_rdata, 32'd0);
        check("wr slv_en drop", 32'(slv_en), 32'd0);
        man_rdy = 4'b0000;
        mst_en  = 1'b0;
        step();
        check("wr ready pulse", 32'(mst_ready), 32'd0);

        xfer("rd_s3_last", 16'h0037, 1'b0, 4'b1000, 16'h000F, 1'b0, 32'hCAFE0003);
        xfer("miss", 16'h0100, 1'b0, 4'b0000, 16'h0000, 1'b1, 32'd0);
        xfer("rd_s0_last", 16'h0007, 1'b0, 4'b0001, 16'h0007, 1'b0, 32'hCAFE0000);
        xfer("rd_s2_last", 16'h0027, 1'b0, 4'b0100, 16'h000F, 1'b0, 32'hCAFE0002);
        xfer("miss_top", 16'h0038, 1'b0, 4'b0000, 16'h0000, 1'b1, 32'd0);
        xfer("wr_s2", 16'h0018, 1'b1, 4'b0100, 16'h0000, 1'b0, 32'd0);

        // back-to-back: mst_en held over three requests
        begin
            int idx;
            idx      = 0;
            auto_rdy = 1'b1;
            mst_en   = 1'b1;
            mst_wr   = 1'b0;
            mst_addr = b2b_addr[0];
            for (int k = 1; k <= 9; k++) begin
                step();
                check("b2b ready", 32'(mst_ready), (k % 3 == 2) ? 32'd1 : 32'd0);
                check("b2b slv_en", 32'(slv_en), (k % 3 == 1) ? 32'(b2b_en[(k-1)/3]) : 32'd0);
                if (k % 3 == 2) check("b2b rdata", mst_rdata, b2b_data[(k-1)/3]);
                if (mst_ready) begin
                    idx++;
                    if (idx < 3) mst_addr = b2b_addr[idx];
                    else mst_en = 1'b0;
                end
            end
            step();
            check("b2b idle", 32'(slv_en), 32'd0);
        end

        // timeout instance: slave 2 never answers
        t_auto  = 1'b0;
        t_en    = 1'b1;
        t_wr    = 1'b0;
        t_addr  = 16'h0018;
        t_wdata = 32'h77;
        t_strb  = 4'hF;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("to slv_en held", 32'(t_slv_en), 32'h4);
            check("to no ready", 32'(t_mst_ready), 32'd0);
            if (k == 1) begin
                check("to slv_wr", 32'(t_slv_wr), 32'd0);
                check("to slv_wdata", t_slv_wdata, 32'h77);
                check("to slv_strb", 32'(t_slv_strb), 32'hF);
            end
        end
        step();
        check("to slv_en drop", 32'(t_slv_en), 32'd0);
        check("to ready", 32'(t_mst_ready), 32'd1);
        check("to err", 32'(t_mst_err), 32'd1);
        check("to rdata", t_mst_rdata, 32'd0);
        t_en = 1'b0;
        step();
        check("to ready pulse", 32'(t_mst_ready), 32'd0);
        t_auto = 1'b1;
        t_en   = 1'b1;
        t_addr = 16'h0002;
        step();
        check("to next slv_en", 32'(t_slv_en), 32'h1);
        check("to next slv_addr", 32'(t_slv_addr), 32'h2);
        step();
        check("to next ready", 32'(t_mst_ready), 32'd1);
        check("to next err", 32'(t_mst_err), 32'd0);
        check("to next rdata", t_mst_rdata, 32'hCAFE0000);
        t_en = 1'b0;
        step();

        // asynchronous reset in ACCESS
        auto_rdy = 1'b0;
        man_rdy  = 4'b0000;
        mst_en   = 1'b1;
        mst_wr   = 1'b0;
        mst_addr = 16'h000C;
        step();
        check("arst pre slv_en", 32'(slv_en), 32'h2);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst slv_en", 32'(slv_en), 32'd0);
        check("arst ready", 32'(mst_ready), 32'd0);
        check("arst slv_addr", 32'(slv_addr), 32'd0);
        mst_en = 1'b0;
        step();
        check("arst held ready", 32'(mst_ready), 32'd0);
        aresetn = 1'b1;
        step();
        check("arst post slv_en", 32'(slv_en), 32'd0);
        check("arst post ready", 32'(mst_ready), 32'd0);
        xfer("post_rst", 16'h0004, 1'b0, 4'b0001, 16'h0004, 1'b0, 32'hCAFE0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
